// File: rtl/dram_timing_guard_pkg.sv
// Shared user types for the DRAM controller: command encoding and address width.
package usertype;

   localparam int unsigned ADDR_BITS = 14;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_ACT  = 3'd1,
      CMD_RD   = 3'd2,
      CMD_WR   = 3'd3,
      CMD_PRE  = 3'd4,
      CMD_PREA = 3'd5,
      CMD_REF  = 3'd6
   } dram_cmd_t;

   // Which timers a command depends on and which ones it restarts.
   typedef struct packed {
      logic is_bus;
      logic is_dummy;
      logic ld_rcd;
      logic ld_ras;
      logic ld_rp;
      logic ld_ccd;
      logic ld_wr;
      logic ld_rtp;
      logic ld_rfc;
   } cmd_decode_t;

   function automatic cmd_decode_t decode_cmd(input logic [2:0] cmd, input logic dummy);
      cmd_decode_t d;
      d = '0;
      case (cmd)
         CMD_ACT:  begin d.is_bus = 1'b1; d.ld_rcd = 1'b1; d.ld_ras = 1'b1; end
         CMD_RD:   begin d.is_bus = 1'b1; d.ld_ccd = 1'b1; d.ld_rtp = 1'b1; end
         CMD_WR:   begin d.is_bus = 1'b1; d.ld_ccd = 1'b1; d.ld_wr  = 1'b1; end
         CMD_PRE,
         CMD_PREA: begin d.is_bus = 1'b1; d.ld_rp  = 1'b1; end
         CMD_REF: begin
            if (dummy) begin
               d.is_dummy = 1'b1;
            end else begin
               d.is_bus = 1'b1;
               d.ld_rfc = 1'b1;
            end
         end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dram_timing_guard_timing_cnt.sv
// Saturating down-counter for one DRAM timing constraint; a load beats the decrement.
module timing_cnt #(
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/dram_timing_guard.sv
// Per-bank timing guard: stalls the bank until a command is legal, then drives it
// onto the DRAM command bus one cycle later. Dummy refreshes are absorbed and counted.
module dram_timing_guard
   import usertype::*;
#(
   parameter int unsigned T_RCD = 4,
   parameter int unsigned T_RAS = 10,
   parameter int unsigned T_RP  = 4,
   parameter int unsigned T_CCD = 2,
   parameter int unsigned T_WR  = 5,
   parameter int unsigned T_RTP = 3,
   parameter int unsigned T_RFC = 110,
   parameter int unsigned CNT_W = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   input  logic [2:0]           issue_cmd,
   input  logic [ADDR_BITS-1:0] issue_addr,
   input  logic                 is_dummy_refresh,
   output logic                 stall,
   output logic                 dram_cmd_valid,
   output logic [2:0]           dram_cmd,
   output logic [ADDR_BITS-1:0] dram_addr,
   output logic [15:0]          skipped_ref_cnt
);

   cmd_decode_t dec;
   logic        ok;
   logic        accept;
   logic        rcd_z, ras_z, rp_z, ccd_z, wr_z, rtp_z, rfc_z;

   always_comb begin
      dec = decode_cmd(issue_cmd, is_dummy_refresh);
      ok  = 1'b1;
      case (issue_cmd)
         CMD_ACT:            ok = rp_z & rfc_z;
         CMD_RD, CMD_WR:     ok = rcd_z & ccd_z;
         CMD_PRE, CMD_PREA:  ok = ras_z & wr_z & rtp_z;
         CMD_REF:            ok = is_dummy_refresh | (rp_z & rfc_z);
         default:            ok = 1'b1;
      endcase
   end

   assign accept = issue_valid & ok;
   assign stall  = issue_valid & ~ok;

   timing_cnt #(.CNT_W(CNT_W)) u_rcd (
      .clk(clk), .rst(rst), .load(accept & dec.ld_rcd),
      .load_val(CNT_W'(T_RCD - 1)), .zero(rcd_z)
   );

   timing_cnt #(.CNT_W(CNT_W)) u_ras (
      .clk(clk), .rst(rst), .load(accept & dec.ld_ras),
      .load_val(CNT_W'(T_RAS - 1)), .zero(ras_z)
   );

   timing_cnt #(.CNT_W(CNT_W)) u_rp (
      .clk(clk), .rst(rst), .load(accept & dec.ld_rp),
      .load_val(CNT_W'(T_RP - 1)), .zero(rp_z)
   );

   timing_cnt #(.CNT_W(CNT_W)) u_ccd (
      .clk(clk), .rst(rst), .load(accept & dec.ld_ccd),
      .load_val(CNT_W'(T_CCD - 1)), .zero(ccd_z)
   );

   timing_cnt #(.CNT_W(CNT_W)) u_wr (
      .clk(clk), .rst(rst), .load(accept & dec.ld_wr),
      .load_val(CNT_W'(T_WR - 1)), .zero(wr_z)
   );

   timing_cnt #(.CNT_W(CNT_W)) u_rtp (
      .clk(clk), .rst(rst), .load(accept & dec.ld_rtp),
      .load_val(CNT_W'(T_RTP - 1)), .zero(rtp_z)
   );

   timing_cnt #(.CNT_W(CNT_W)) u_rfc (
      .clk(clk), .rst(rst), .load(accept & dec.ld_rfc),
      .load_val(CNT_W'(T_RFC - 1)), .zero(rfc_z)
   );

   // Address is held across idle cycles so the bus only toggles on real commands.
   always_ff @(posedge clk) begin
      if (rst) begin
         dram_cmd_valid <= 1'b0;
         dram_cmd       <= CMD_NOP;
         dram_addr      <= '0;
      end else if (accept && dec.is_bus) begin
         dram_cmd_valid <= 1'b1;
         dram_cmd       <= issue_cmd;
         dram_addr      <= issue_addr;
      end else begin
         dram_cmd_valid <= 1'b0;
         dram_cmd       <= CMD_NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skipped_ref_cnt <= '0;
      end else if (accept && dec.is_dummy) begin
         skipped_ref_cnt <= skipped_ref_cnt + 16'd1;
      end
   end

endmodule
